stage5_writeback: RTL and testbench

STAGE5_WRITEBACK -- requirements
Module: stage5_writeback

---
 rtl/stage5_writeback_pkg.sv | 45 ++++
 rtl/stage5_writeback_wb_decode.sv | 91 +++++++++
 rtl/stage5_writeback.sv | 125 ++++++++++++
 tb/tb_stage5_writeback.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stage5_writeback_pkg.sv
// rtl/stage5_writeback_pkg.sv - shared pipeline ISA constants, special registers and writeback FSM states
package stage5_writeback_pkg;

  // Opcodes, IR[31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops, IR[6:2]
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Special registers
  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_RA     = 5'd31;

  // Status codes written to r30 on overflow / multdiv exception
  localparam logic [31:0] STAT_ADD_OVF  = 32'd1;
  localparam logic [31:0] STAT_ADDI_OVF = 32'd2;
  localparam logic [31:0] STAT_SUB_OVF  = 32'd3;
  localparam logic [31:0] STAT_MULT_EXC = 32'd4;
  localparam logic [31:0] STAT_DIV_EXC  = 32'd5;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } wb_state_e;

  // True when the IR is an R-type mult or div, which completes through the multdiv unit.
  function automatic logic is_md_op(input logic [31:0] ir);
    return (ir[31:27] == OP_RTYPE) && ((ir[6:2] == ALU_MULT) || (ir[6:2] == ALU_DIV));
  endfunction

endpackage

// File: rtl/stage5_writeback_wb_decode.sv
// rtl/stage5_writeback_wb_decode.sv - writeback decode and register-file write-port select
module wb_decode
  import stage5_writeback_pkg::*;
(
  input  logic [31:0] i_ir,
  input  logic [31:0] i_o,
  input  logic [31:0] i_d,
  input  logic [31:0] i_pc1,
  input  logic        i_ovf,
  input  logic        i_md_wait,
  input  logic        i_md_ready,
  input  logic [31:0] i_md_result,
  input  logic        i_md_exception,
  output logic        o_is_md,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata
);

  logic [4:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_aluop;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;

  assign w_opcode = i_ir[31:27];
  assign w_rd     = i_ir[26:22];
  assign w_aluop  = i_ir[6:2];
  assign o_is_md  = is_md_op(i_ir);

  // Pick destination and data; the multdiv result replaces normal decode while waiting on it.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_rd;
    w_wdata = i_o;
    if (i_md_wait) begin
      if (i_md_ready) begin
        w_we = 1'b1;
        if (i_md_exception) begin
          w_waddr = REG_STATUS;
          w_wdata = (w_aluop == ALU_MULT) ? STAT_MULT_EXC : STAT_DIV_EXC;
        end else begin
          w_wdata = i_md_result;
        end
      end
    end else begin
      case (w_opcode)
        OP_RTYPE: begin
          w_we = !o_is_md;
          if (i_ovf && (w_aluop == ALU_ADD)) begin
            w_waddr = REG_STATUS;
            w_wdata = STAT_ADD_OVF;
          end else if (i_ovf && (w_aluop == ALU_SUB)) begin
            w_waddr = REG_STATUS;
            w_wdata = STAT_SUB_OVF;
          end
        end
        OP_ADDI: begin
          w_we = 1'b1;
          if (i_ovf) begin
            w_waddr = REG_STATUS;
            w_wdata = STAT_ADDI_OVF;
          end
        end
        OP_LW: begin
          w_we    = 1'b1;
          w_wdata = i_d;
        end
        OP_JAL: begin
          w_we    = 1'b1;
          w_waddr = REG_RA;
          w_wdata = i_pc1;
        end
        OP_SETX: begin
          w_we    = 1'b1;
          w_waddr = REG_STATUS;
          w_wdata = {5'b00000, i_ir[26:0]};
        end
        OP_SW, OP_J, OP_BNE, OP_BLT, OP_JR, OP_BEX: w_we = 1'b0;
        default: w_we = 1'b0;
      endcase
    end
  end

  // r0 is hardwired to zero, so writes to it are suppressed here.
  assign o_we    = w_we && (w_waddr != REG_ZERO);
  assign o_waddr = w_waddr;
  assign o_wdata = w_wdata;

endmodule

// File: rtl/stage5_writeback.sv
// rtl/stage5_writeback.sv - pipeline stage 5 writeback with multdiv wait FSM; optional WB_FWD_EN forwarding port
module stage5_writeback
  import stage5_writeback_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] ir_in,
  input  logic [31:0] o_in,
  input  logic [31:0] d_in,
  input  logic [31:0] pc1_in,
  input  logic        ovf_in,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        stall_out,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] ir_wb
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data
`endif
);

  wb_state_e   r_state;
  wb_state_e   w_next_state;
  logic [31:0] r_ir;
  logic [31:0] r_o;
  logic [31:0] r_d;
  logic [31:0] r_pc1;
  logic        r_ovf;
  logic        w_is_md;
  logic        w_md_wait;
  logic        w_stall;

  assign w_md_wait = (r_state == ST_MD_WAIT);

  // Next state and stall: a latched mult/div must hold the latches until its result returns.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_is_md) begin
          w_stall      = 1'b1;
          w_next_state = ST_MD_WAIT;
        end
      end
      ST_MD_WAIT: begin
        w_stall = 1'b1;
        if (md_ready) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Stage latches: load on accept, nop when idle or when a multdiv op retires, hold while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ir  <= 32'd0;
      r_o   <= 32'd0;
      r_d   <= 32'd0;
      r_pc1 <= 32'd0;
      r_ovf <= 1'b0;
    end else if (w_md_wait) begin
      if (md_ready) begin
        r_ir  <= 32'd0;
        r_o   <= 32'd0;
        r_d   <= 32'd0;
        r_pc1 <= 32'd0;
        r_ovf <= 1'b0;
      end
    end else if (!w_stall) begin
      if (in_valid) begin
        r_ir  <= ir_in;
        r_o   <= o_in;
        r_d   <= d_in;
        r_pc1 <= pc1_in;
        r_ovf <= ovf_in;
      end else begin
        r_ir  <= 32'd0;
        r_o   <= 32'd0;
        r_d   <= 32'd0;
        r_pc1 <= 32'd0;
        r_ovf <= 1'b0;
      end
    end
  end

  wb_decode u_wb_decode (
    .i_ir          (r_ir),
    .i_o           (r_o),
    .i_d           (r_d),
    .i_pc1         (r_pc1),
    .i_ovf         (r_ovf),
    .i_md_wait     (w_md_wait),
    .i_md_ready    (md_ready),
    .i_md_result   (md_result),
    .i_md_exception(md_exception),
    .o_is_md       (w_is_md),
    .o_we          (rf_we),
    .o_waddr       (rf_waddr),
    .o_wdata       (rf_wdata)
  );

  assign stall_out = w_stall;
  assign ir_wb     = r_ir;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_stage5_writeback.sv
// tb/tb_stage5_writeback.sv - scoreboard bench for stage5_writeback
module tb_stage5_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] ir_in;
  logic [31:0] o_in;
  logic [31:0] d_in;
  logic [31:0] pc1_in;
  logic        ovf_in;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        stall_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] ir_wb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_data;
    logic        stall;
    logic [31:0] ir;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  stage5_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .ir_in       (ir_in),
    .o_in        (o_in),
    .d_in        (d_in),
    .pc1_in      (pc1_in),
    .ovf_in      (ovf_in),
    .md_ready    (md_ready),
    .md_result   (md_result),
    .md_exception(md_exception),
    .stall_out   (stall_out),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .ir_wb       (ir_wb)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
    return {op, rd, 5'd0, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data,
                          input logic chk_data, input logic stall, input logic [31:0] ir);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.chk_data = chk_data; e.stall = stall; e.ir = ir;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_we"}, {31'd0, rf_we}, {31'd0, e.we});
      if (e.chk_data) begin
        chk({t, "_waddr"}, {27'd0, rf_waddr}, {27'd0, e.addr});
        chk({t, "_wdata"}, rf_wdata, e.data);
      end
      chk({t, "_stall"}, {31'd0, stall_out}, {31'd0, e.stall});
      chk({t, "_ir_wb"}, ir_wb, e.ir);
    end
  endtask

  task automatic retire(input string tag, input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                        input logic [31:0] pc1, input logic ovf, input logic we, input logic [4:0] addr,
                        input logic [31:0] data, input logic stall);
    @(negedge clock);
    in_valid = 1'b1; ir_in = ir; o_in = o; d_in = d; pc1_in = pc1; ovf_in = ovf;
    push_exp(tag, we, addr, data, we, stall, ir);
    @(posedge clock); #1;
    in_valid = 1'b0; ovf_in = 1'b0;
    pop_check();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b1; ir_in = enc_i(5'b00101, 5'd5, 17'd7); o_in = 32'd7;
    d_in = 32'd0; pc1_in = 32'd0; ovf_in = 1'b0;
    md_ready = 1'b0; md_result = 32'd0; md_exception = 1'b0;

    // Reset holds everything at zero even with a valid instruction offered.
    push_exp("reset", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    repeat (2) @(posedge clock);
    #1 pop_check();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;

    // Ordinary retirement patterns.
    retire("addi_r5",  enc_i(5'b00101, 5'd5, 17'd7), 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'd7, 1'b0);
    retire("lw_r3",    enc_i(5'b01000, 5'd3, 17'd0), 32'd100, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
    retire("sw",       enc_i(5'b00111, 5'd3, 17'd4), 32'd104, 32'h1234, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    retire("add_ovf",  enc_r(5'd7, 5'b00000), 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd1, 1'b0);
    retire("add_r0",   enc_r(5'd0, 5'b00000), 32'd55, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    retire("addi_ovf", enc_i(5'b00101, 5'd6, 17'd1), 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd2, 1'b0);
    retire("sub_ovf",  enc_r(5'd7, 5'b00001), 32'h7FFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b1, 5'd30, 32'd3, 1'b0);
    retire("and_r9",   enc_r(5'd9, 5'b00010), 32'h0000_00F0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9, 32'hF0, 1'b0);
    retire("jal",      {5'b00011, 27'd200}, 32'd0, 32'd0, 32'h123, 1'b0, 1'b1, 5'd31, 32'h123, 1'b0);
    retire("setx",     {5'b10101, 27'h4ABCDEF}, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd30, 32'h04ABCDEF, 1'b0);
    retire("bne",      {5'b00010, 5'd4, 5'd5, 17'd3}, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    retire("j",        {5'b00001, 27'd40}, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Idle cycle retires a nop.
    push_exp("nop", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clock); #1 pop_check();

    // mult r4: three stalled cycles, result on the third, released at the following edge.
    retire("mult_latch", enc_r(5'd4, 5'b00110), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    in_valid = 1'b1; ir_in = enc_i(5'b00101, 5'd9, 17'd1); o_in = 32'd1;
    push_exp("mult_wait", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, enc_r(5'd4, 5'b00110));
    @(posedge clock); #1 pop_check();
    @(posedge clock); #1;
    md_ready = 1'b1; md_result = 32'd42;
    push_exp("mult_done", 1'b1, 5'd4, 32'd42, 1'b1, 1'b1, enc_r(5'd4, 5'b00110));
    #1 pop_check();
    push_exp("mult_exit", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clock); #1;
    md_ready = 1'b0; md_result = 32'd0; in_valid = 1'b0;
    pop_check();

    // div with exception writes status code 5 to r30.
    retire("div_latch", enc_r(5'd6, 5'b00111), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(posedge clock); #1;
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd99;
    push_exp("div_exc", 1'b1, 5'd30, 32'd5, 1'b1, 1'b1, enc_r(5'd6, 5'b00111));
    #1 pop_check();
    push_exp("div_exit", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clock); #1;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'd0;
    pop_check();

    // Stray md_ready while running: no write, no stall, normal writeback data unaffected.
    md_ready = 1'b1; md_result = 32'd77;
    push_exp("stray_nop", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1 pop_check();
    retire("stray_addi", enc_i(5'b00101, 5'd8, 17'd11), 32'd11, 32'd0, 32'd0, 1'b0, 1'b1, 5'd8, 32'd11, 1'b0);
    push_exp("stray_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clock); #1 pop_check();
    md_ready = 1'b0; md_result = 32'd0;

    // Reset in the middle of a multdiv wait discards it at once.
    retire("mult2_latch", enc_r(5'd4, 5'b00110), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    push_exp("rst_md", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    #1 pop_check();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    md_ready = 1'b1; md_result = 32'd42;
    push_exp("rst_late_ready", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1 pop_check();
    push_exp("rst_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(posedge clock); #1;
    md_ready = 1'b0; md_result = 32'd0;
    pop_check();
    retire("resume_addi", enc_i(5'b00101, 5'd5, 17'd7), 32'd7, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'd7, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
